// File: rtl/kronecker_driver.sv
// kronecker_driver: masks input bytes for a downstream masked zero-test
// and queues unmasked results in a small FIFO.
// Ports: clk, rst_n (async, active-low)
//   in_valid/in_data/in_ready : unmasked byte in
//   reseed/seed               : LFSR reload
//   shr_data/shr_rand         : masked byte and fresh randomness out
//   z_shares                  : masked zero-test result in (LAT later)
//   out_valid/out_z/out_ready : unmasked result out
//   busy                      : bytes in flight or results queued
module kronecker_driver #(
   parameter int          LAT   = 3,
   parameter logic [31:0] SEED  = 32'hACE1_2468,
   parameter int          DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        reseed,
   input  logic [31:0] seed,
   output logic [15:0] shr_data,
   output logic [2:0]  shr_rand,
   input  logic [1:0]  z_shares,
   output logic        out_valid,
   output logic        out_z,
   input  logic        out_ready,
   output logic        busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
   localparam logic [31:0] POLY = 32'h8020_0003;

   logic [31:0]      lfsr;
   logic [31:0]      lfsr_nxt;
   logic             run;
   logic [LAT:0]     vld;
   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      cnt;
   logic             accept;
   logic             push;
   logic             pop;
   logic [31:0]      total;

   always_comb begin
      lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);
      if (reseed) begin
         // an all-zero state would lock the LFSR
         lfsr_nxt = (seed == 32'h0) ? 32'h1 : seed;
      end
   end

   assign push      = vld[LAT];
   assign pop       = out_valid & out_ready;
   assign accept    = in_valid & in_ready;
   assign out_valid = (cnt != '0);
   assign out_z     = out_valid & mem[rptr];
   assign busy      = (|vld) | out_valid;
   assign shr_rand  = lfsr[10:8];

   // Reserve a FIFO slot for every byte in flight; a pop this
   // cycle frees a slot for a same-cycle accept.
   always_comb begin
      total = 32'(cnt) - 32'(pop);
      for (int i = 0; i <= LAT; i++) begin
         total = total + 32'(vld[i]);
      end
   end

   assign in_ready = run & (total < 32'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr     <= SEED;
         run      <= 1'b0;
         shr_data <= '0;
         vld      <= '0;
         mem      <= '0;
         wptr     <= '0;
         rptr     <= '0;
         cnt      <= '0;
      end else begin
         lfsr <= lfsr_nxt;
         run  <= 1'b1;
         // bubbles carry equal shares so no stale byte leaks
         shr_data <= {lfsr[7:0],
                      (accept ? in_data : 8'h00) ^ lfsr[7:0]};
         vld <= (vld << 1) | (LAT+1)'(accept);
         if (push) begin
            // shares recombine only here, never stored apart
            mem[wptr] <= z_shares[1] ^ z_shares[0];
            wptr      <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

endmodule
